// File: rtl/gng_pkg.sv
// Shared widths, fixed-point formats and saturation helper for the noise adder.
// s<16,11> samples, u<16,12> sigma; products carried at full precision.
package gng_pkg;

  localparam int NOISE_W    = 16;
  localparam int NOISE_FRAC = 11;
  localparam int SCALE_W    = 16;
  localparam int SCALE_FRAC = 12;
  localparam logic [NOISE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [NOISE_W-1:0] SAT_MIN = 16'h8000;

  // Signed noise times zero-extended sigma: s<33,23>.
  localparam int PROD_W = NOISE_W + SCALE_W + 1;
  localparam logic signed [PROD_W-1:0] RND_BIAS = PROD_W'(1 << (SCALE_FRAC - 1));
  localparam logic signed [PROD_W-1:0] SUM_MAX  = {{(PROD_W-NOISE_W){1'b0}}, SAT_MAX};
  localparam logic signed [PROD_W-1:0] SUM_MIN  = {{(PROD_W-NOISE_W){1'b1}}, SAT_MIN};

  typedef logic [NOISE_W-1:0] sample_t;

  typedef struct packed {
    logic    sat;
    sample_t dat;
  } sat_res_t;

  function automatic sat_res_t saturate(input logic signed [PROD_W-1:0] sum);
    sat_res_t r;
    r.sat = 1'b0;
    r.dat = sum[NOISE_W-1:0];
    if (sum > SUM_MAX) begin
      r.sat = 1'b1;
      r.dat = SAT_MAX;
    end else if (sum < SUM_MIN) begin
      r.sat = 1'b1;
      r.dat = SAT_MIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/gng_sfifo.sv
// Single-clock FIFO with fill count and overflow pulse; head is read combinationally.
// Writes when full are dropped unless a read happens the same cycle; reads when empty are ignored.
module gng_sfifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_vld,
  output logic [W-1:0]  rd_dat,
  output logic [AW:0]   fill,
  output logic [AW:0]   fill_nxt,
  output logic          ovf
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          full, empty, wr_en, rd_en;

  assign full   = (fill_q == (AW+1)'(DEPTH));
  assign empty  = (fill_q == '0);
  assign rd_en  = rd_vld && !empty;
  assign wr_en  = wr_vld && (!full || rd_en);
  assign ovf    = wr_vld && full && !rd_en;
  assign rd_dat = mem_q[rptr_q];
  assign fill   = fill_q;
  assign fill_nxt = fill_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (wr_en) begin
      mem_d[wptr_q] = wr_dat;
      wptr_d        = wptr_q + AW'(1);
    end
    if (rd_en) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/gng_awgn_add.sv
// Adds sigma-scaled buffered noise to a signal stream with saturation; 2-cycle accept-to-output latency.
// Credit-throttled noise input never overflows; out_ready low freezes both pipeline stages.
module gng_awgn_add
  import gng_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               noise_ce,
  input  logic               noise_valid,
  input  logic [NOISE_W-1:0] noise_data,
  input  logic [SCALE_W-1:0] scale,
  input  logic               sig_valid,
  output logic               sig_ready,
  input  logic [NOISE_W-1:0] sig_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NOISE_W-1:0] out_data,
  output logic               out_sat,
  output logic               err_ovf,
  input  logic               err_clr
);

  logic [AW:0]   fifo_fill, fifo_fill_nxt;
  logic          fifo_ovf;
  sample_t       noise_head;

  logic [AW:0]   pend_q, pend_d;
  logic          noise_ce_q, noise_ce_d;
  logic [AW+1:0] credit_sum;
  logic          err_ovf_q, err_ovf_d;

  logic          advance, accept;
  logic          s1_vld_q, s1_vld_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  sample_t       sig1_q, sig1_d;
  logic          out_vld_q, out_vld_d;
  sat_res_t      out_res_q, out_res_d;

  logic signed [PROD_W-1:0] noise_ext, scale_ext, prod_rnd, sig_ext, sum;

  assign advance   = !out_vld_q || out_ready;
  assign sig_ready = advance && (fifo_fill != '0);
  assign accept    = sig_valid && sig_ready;

  gng_sfifo #(
    .W     (NOISE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_noise_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_vld   (noise_valid),
    .wr_dat   (noise_data),
    .rd_vld   (accept),
    .rd_dat   (noise_head),
    .fill     (fifo_fill),
    .fill_nxt (fifo_fill_nxt),
    .ovf      (fifo_ovf)
  );

  // Credits use next-cycle fill and pending so a request is never issued one cycle too many.
  // Pending never goes below zero: samples still in flight across a reset arrive uncredited.
  always_comb begin
    pend_d = pend_q;
    case ({noise_ce_q, noise_valid && (pend_q != '0)})
      2'b10:   pend_d = pend_q + (AW+1)'(1);
      2'b01:   pend_d = pend_q - (AW+1)'(1);
      default: pend_d = pend_q;
    endcase
    credit_sum = {1'b0, fifo_fill_nxt} + {1'b0, pend_d};
    noise_ce_d = (credit_sum < (AW+2)'(DEPTH));
    err_ovf_d  = fifo_ovf || (err_ovf_q && !err_clr);
  end

  always_comb begin
    noise_ext = {{(PROD_W-NOISE_W){noise_head[NOISE_W-1]}}, noise_head};
    scale_ext = {{(PROD_W-SCALE_W){1'b0}}, scale};
    s1_vld_d  = s1_vld_q;
    prod_d    = prod_q;
    sig1_d    = sig1_q;
    if (advance) begin
      s1_vld_d = accept;
      if (accept) begin
        prod_d = noise_ext * scale_ext;
        sig1_d = sig_data;
      end
    end
  end

  // Sum kept at product width; value-identical to the narrower s<22,11> sum.
  always_comb begin
    prod_rnd  = prod_q + RND_BIAS;
    sig_ext   = {{(PROD_W-NOISE_W){sig1_q[NOISE_W-1]}}, sig1_q};
    sum       = (prod_rnd >>> SCALE_FRAC) + sig_ext;
    out_vld_d = out_vld_q;
    out_res_d = out_res_q;
    if (advance) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_res_d = saturate(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q     <= '0;
      noise_ce_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      prod_q     <= '0;
      sig1_q     <= '0;
      out_vld_q  <= 1'b0;
      out_res_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      noise_ce_q <= noise_ce_d;
      err_ovf_q  <= err_ovf_d;
      s1_vld_q   <= s1_vld_d;
      prod_q     <= prod_d;
      sig1_q     <= sig1_d;
      out_vld_q  <= out_vld_d;
      out_res_q  <= out_res_d;
    end
  end

  assign noise_ce  = noise_ce_q;
  assign err_ovf   = err_ovf_q;
  assign out_valid = out_vld_q;
  assign out_data  = out_res_q.dat;
  assign out_sat   = out_res_q.sat;

endmodule

// File: tb/tb_gng_awgn_add.sv
// Bench for gng_awgn_add: latency-6 generator model, fixed vectors, random backpressured stream, overflow/clear.
module tb_gng_awgn_add;

  localparam int GEN_LAT = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        noise_ce;
  logic        noise_valid = 1'b0;
  logic [15:0] noise_data = 16'h0;
  logic [15:0] scale = 16'h0;
  logic        sig_valid = 1'b0;
  logic        sig_ready;
  logic [15:0] sig_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;
  logic        err_ovf;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  gng_awgn_add #(.DEPTH(8), .AW(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .noise_ce    (noise_ce),
    .noise_valid (noise_valid),
    .noise_data  (noise_data),
    .scale       (scale),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .sig_data    (sig_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .err_ovf     (err_ovf),
    .err_clr     (err_clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] n, input logic [15:0] s, input logic [15:0] g);
    longint p, r, sm;
    p  = longint'($signed(n)) * longint'(s);
    r  = (p + 2048) >>> 12;
    sm = longint'($signed(g)) + r;
    if (sm > 32767)  return {1'b1, 16'h7FFF};
    if (sm < -32768) return {1'b1, 16'h8000};
    return {1'b0, sm[15:0]};
  endfunction

  // Generator model: every noise_ce cycle yields one sample GEN_LAT cycles later.
  logic [15:0] src_q[$];
  logic [15:0] noise_model_q[$];
  logic        dl_vld [GEN_LAT] = '{default: 1'b0};
  logic [15:0] dl_dat [GEN_LAT] = '{default: 16'h0};
  logic        force_nv = 1'b0;
  int          ce_cnt = 0;

  always @(negedge clk) begin
    if (noise_ce) ce_cnt++;
    for (int i = GEN_LAT - 1; i > 0; i--) begin
      dl_vld[i] = dl_vld[i-1];
      dl_dat[i] = dl_dat[i-1];
    end
    dl_vld[0] = noise_ce;
    dl_dat[0] = 16'h0;
    if (noise_ce) begin
      if (src_q.size() > 0) dl_dat[0] = src_q.pop_front();
      else                  dl_dat[0] = 16'($urandom);
    end
    noise_valid = dl_vld[GEN_LAT-1] | force_nv;
    noise_data  = dl_dat[GEN_LAT-1];
    if (dl_vld[GEN_LAT-1]) noise_model_q.push_back(dl_dat[GEN_LAT-1]);
  end

  // Scoreboard and stall-stability monitor.
  logic [16:0] exp_q[$];
  int          n_out = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_out = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_stall) check("stall_hold", {15'h0, out_valid, out_sat, out_data}, {15'h0, 1'b1, prev_out});
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %h expected no output", {out_sat, out_data});
        end else begin
          check("out", {15'h0, out_sat, out_data}, {15'h0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_sat, out_data};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] noise;
    logic [15:0] scl;
    logic [15:0] sig;
    logic [15:0] exp_dat;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[8];
  logic stim_done = 1'b0;

  task automatic wait_ready(input string name);
    int w = 0;
    @(negedge clk);
    while (!sig_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!sig_ready) begin
      total++;
      bad++;
      $display("FAIL %s: sig_ready stayed %b, required 1", name, sig_ready);
    end
  endtask

  initial begin
    vecs[0] = '{"unity",    16'h0800, 16'h1000, 16'h1000, 16'h1800, 1'b0};
    vecs[1] = '{"rnd_up",   16'h0001, 16'h0800, 16'h0000, 16'h0001, 1'b0};
    vecs[2] = '{"rnd_neg",  16'hFFFF, 16'h0800, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{"sat_pos",  16'h2000, 16'h1000, 16'h7000, 16'h7FFF, 1'b1};
    vecs[4] = '{"sat_neg",  16'hE000, 16'h1000, 16'h8800, 16'h8000, 1'b1};
    vecs[5] = '{"zero_scl", 16'h0800, 16'h0000, 16'h1234, 16'h1234, 1'b0};
    vecs[6] = '{"max_mag",  16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b1};
    vecs[7] = '{"rnd_dn",   16'h7FFF, 16'h0001, 16'h0000, 16'h0008, 1'b0};
    foreach (vecs[i]) src_q.push_back(vecs[i].noise);

    repeat (3) @(posedge clk);
    #1;
    check("rst_noise_ce",  {31'h0, noise_ce},  32'h0);
    check("rst_sig_ready", {31'h0, sig_ready}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {16'h0, out_data},  32'h0);
    check("rst_out_sat",   {31'h0, out_sat},   32'h0);
    check("rst_err_ovf",   {31'h0, err_ovf},   32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Credit throttle with no reads.
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("thr_ce_count", 32'(ce_cnt), 32'd8);
    check("thr_fill",     32'(dut.fifo_fill), 32'd8);
    check("thr_ce_low",   {31'h0, noise_ce}, 32'h0);
    check("thr_err_ovf",  {31'h0, err_ovf},  32'h0);
    check("thr_ready",    {31'h0, sig_ready}, 32'h1);

    // Fixed vectors, one at a time, with exact latency.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      scale     = vecs[i].scl;
      sig_data  = vecs[i].sig;
      sig_valid = 1'b1;
      wait_ready(vecs[i].name);
      exp_q.push_back({vecs[i].exp_sat, vecs[i].exp_dat});
      if (noise_model_q.size() > 0) void'(noise_model_q.pop_front());
      @(posedge clk);
      #1 sig_valid = 1'b0;
      @(negedge clk);
      check({vecs[i].name, "_lat1"}, {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      check({vecs[i].name, "_lat2"}, {31'h0, out_valid}, 32'h1);
    end

    // Random stream under toggling backpressure, then a long stall.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          sig_valid = 1'b1;
          sig_data  = 16'($urandom);
          scale     = 16'($urandom_range(0, 16'h1800));
          wait_ready("stream_ready");
          if (noise_model_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stream_model: accept seen with %0d modelled noise entries, required >0", noise_model_q.size());
          end else begin
            exp_q.push_back(model(noise_model_q.pop_front(), scale, sig_data));
          end
        end
        @(posedge clk);
        #1 sig_valid = 1'b0;
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("out_count",  32'(n_out), 32'd28);

    // Overflow and sticky clear.
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("ovf_pre_fill", 32'(dut.fifo_fill), 32'd8);
    check("ovf_pre_err",  {31'h0, err_ovf}, 32'h0);
    @(posedge clk);
    #1 force_nv = 1'b1;
    @(posedge clk);
    #1 force_nv = 1'b0;
    @(negedge clk);
    check("ovf_set",  {31'h0, err_ovf}, 32'h1);
    check("ovf_fill", 32'(dut.fifo_fill), 32'd8);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("clr_only", {31'h0, err_ovf}, 32'h0);
    @(posedge clk);
    #1;
    err_clr  = 1'b1;
    force_nv = 1'b1;
    @(posedge clk);
    #1;
    err_clr  = 1'b0;
    force_nv = 1'b0;
    @(negedge clk);
    check("clr_vs_set", {31'h0, err_ovf}, 32'h1);
    check("clr_fill",   32'(dut.fifo_fill), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
